key_cmd_scheduler: RTL and testbench

Sits between `key_encoder` and the game FSM. Turns the encoder's level-style `keycode`/`keystrobe` pair into discrete key commands. Each command is emitted once on press, then auto-repeated for keys enabled for repeat while they stay held. Commands are buffered in a small FIFO and handed to the consumer over a valid/ready handshake, so no key event is lost while the game FSM is busy.

---
 rtl/key_cmd_scheduler.sv | 144 ++++++++++++++
 tb/tb_key_cmd_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_scheduler.sv
// Purpose: turns key_encoder level output into press / auto-repeat key commands queued in a small FIFO.
// Latency: a command enqueued at a rising edge is visible on cmd_valid/cmd_code right after that edge.
// Backpressure: cmd_ready stalls the FIFO head; an enqueue into a full FIFO with no pop is dropped and sets overflow.
module key_cmd_scheduler #(
   parameter logic [23:0] DELAY       = 24'd6_000_000,
   parameter logic [23:0] PERIOD      = 24'd1_500_000,
   parameter logic [12:0] REPEAT_MASK = 13'h00F,
   parameter int          DEPTH       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] keycode,
   input  logic       keystrobe,
   output logic [3:0] cmd_code,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic       held,
   output logic       overflow
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

   state_t      state;
   logic [3:0]  cur;
   logic [23:0] cnt;

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [3:0]  mem [DEPTH];

   logic        key_ok;
   logic [15:0] mask16;
   logic        enq;
   logic        full;
   logic        empty;
   logic        pop;
   logic        push;

   // codes 13..15 behave exactly like no key being held
   assign key_ok = keystrobe && (keycode <= 4'd12);
   assign mask16 = {3'b000, REPEAT_MASK};

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_valid = !empty;
   assign cmd_code  = mem[rd_ptr[AW-1:0]];
   assign pop       = cmd_valid && cmd_ready;
   // a pop in the same edge frees the slot, so a full FIFO can still accept
   assign push      = enq && (!full || pop);

   // decide whether the FSM produces a command this edge; the enqueued code always equals keycode
   always_comb begin
      enq = 1'b0;
      case (state)
         IDLE: enq = key_ok;
         HELD: begin
            if (!key_ok)
               enq = 1'b0;
            else if (keycode != cur)
               enq = 1'b1;
            else
               enq = mask16[cur] && (cnt == DELAY - 24'd1);
         end
         default: begin
            if (!key_ok)
               enq = 1'b0;
            else if (keycode != cur)
               enq = 1'b1;
            else
               enq = (cnt == PERIOD - 24'd1);
         end
      endcase
   end

   // key tracking FSM: press detection, initial delay, repeat period, registered held flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cur   <= 4'd0;
         cnt   <= 24'd0;
         held  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (key_ok) begin
                  cur   <= keycode;
                  cnt   <= 24'd0;
                  state <= HELD;
                  held  <= 1'b1;
               end
            end
            default: begin
               if (!key_ok) begin
                  state <= IDLE;
                  held  <= 1'b0;
               end else if (keycode != cur) begin
                  cur   <= keycode;
                  cnt   <= 24'd0;
                  state <= HELD;
                  held  <= 1'b1;
               end else if (state == HELD) begin
                  // non-repeating keys park here with cnt frozen
                  if (mask16[cur]) begin
                     if (cnt == DELAY - 24'd1) begin
                        cnt   <= 24'd0;
                        state <= REPEAT;
                     end else begin
                        cnt <= cnt + 24'd1;
                     end
                  end
               end else begin
                  if (cnt == PERIOD - 24'd1)
                     cnt <= 24'd0;
                  else
                     cnt <= cnt + 24'd1;
               end
            end
         endcase
      end
   end

   // command FIFO with extra pointer bit for full/empty, plus sticky drop flag
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= 4'd0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= keycode;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
         if (enq && full && !pop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler with short DELAY/PERIOD.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Each scenario task checks its own expected values inline.
module tb_key_cmd_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] keycode = 4'd0;
   logic       keystrobe = 1'b0;
   logic [3:0] cmd_code;
   logic       cmd_valid;
   logic       cmd_ready = 1'b0;
   logic       held;
   logic       overflow;

   int n_cmp = 0;
   int n_err = 0;

   key_cmd_scheduler #(
      .DELAY(24'd4),
      .PERIOD(24'd2),
      .REPEAT_MASK(13'h00F),
      .DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .keycode(keycode),
      .keystrobe(keystrobe),
      .cmd_code(cmd_code),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .held(held),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      keystrobe = 1'b0;
      keycode = 4'd0;
      cmd_ready = 1'b0;
      tick;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", cmd_valid); end
      n_cmp++; if (cmd_code !== 4'd0) begin n_err++; $display("FAIL rst_code: got %0d want 0", cmd_code); end
      n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL rst_held: got %b want 0", held); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_single_tap;
      do_reset;
      cmd_ready = 1'b1;
      keystrobe = 1'b1;
      keycode = 4'd5;
      tick;
      n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL tap_valid1: got %b want 1", cmd_valid); end
      n_cmp++; if (cmd_code !== 4'd5) begin n_err++; $display("FAIL tap_code: got %0d want 5", cmd_code); end
      n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL tap_held1: got %b want 1", held); end
      tick;
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL tap_valid2: got %b want 0", cmd_valid); end
      n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL tap_held2: got %b want 1", held); end
      keystrobe = 1'b0;
      tick;
      n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL tap_held3: got %b want 0", held); end
      tick;
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL tap_valid3: got %b want 0", cmd_valid); end
      cmd_ready = 1'b0;
   endtask

   task automatic test_repeat_overflow;
      do_reset;
      keystrobe = 1'b1;
      keycode = 4'd2;
      // edges E0..E0+9 see the key held: pushes at E0, +4, +6, +8
      for (int i = 0; i < 10; i++) tick;
      keystrobe = 1'b0;
      tick;
      n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL rep_held_rel: got %b want 0", held); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rep_ovf0: got %b want 0", overflow); end
      n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL rep_valid: got %b want 1", cmd_valid); end
      keystrobe = 1'b1;
      tick;
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL rep_ovf1: got %b want 1", overflow); end
      n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL rep_held2: got %b want 1", held); end
      tick;
      keystrobe = 1'b0;
      tick;
      tick;
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL rep_ovf_sticky: got %b want 1", overflow); end
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL rep_drain_valid[%0d]: got %b want 1", i, cmd_valid); end
         n_cmp++; if (cmd_code !== 4'd2) begin n_err++; $display("FAIL rep_drain_code[%0d]: got %0d want 2", i, cmd_code); end
         tick;
      end
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL rep_empty: got %b want 0", cmd_valid); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL rep_ovf_end: got %b want 1", overflow); end
      cmd_ready = 1'b0;
   endtask

   task automatic test_no_repeat_switch;
      do_reset;
      keystrobe = 1'b1;
      keycode = 4'd8;
      for (int i = 0; i < 20; i++) tick;
      n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL sw_held8: got %b want 1", held); end
      keycode = 4'd9;
      tick;
      n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL sw_held9: got %b want 1", held); end
      n_cmp++; if (dut.cnt !== 24'd0) begin n_err++; $display("FAIL sw_cnt: got %0d want 0", dut.cnt); end
      tick;
      keystrobe = 1'b0;
      tick;
      cmd_ready = 1'b1;
      n_cmp++; if (cmd_code !== 4'd8) begin n_err++; $display("FAIL sw_code8: got %0d want 8", cmd_code); end
      tick;
      n_cmp++; if (cmd_code !== 4'd9) begin n_err++; $display("FAIL sw_code9: got %0d want 9", cmd_code); end
      n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL sw_valid9: got %b want 1", cmd_valid); end
      tick;
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL sw_empty: got %b want 0", cmd_valid); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL sw_ovf: got %b want 0", overflow); end
      cmd_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [3:0] exp_q [4];
      exp_q = '{4'd1, 4'd3, 4'd5, 4'd6};
      do_reset;
      keystrobe = 1'b1;
      keycode = 4'd0; tick;
      keycode = 4'd1; tick;
      keycode = 4'd3; tick;
      keycode = 4'd5; tick;
      n_cmp++; if (cmd_code !== 4'd0) begin n_err++; $display("FAIL b2b_head: got %0d want 0", cmd_code); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf_full: got %b want 0", overflow); end
      keycode = 4'd6;
      cmd_ready = 1'b1;
      tick;
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf_pp: got %b want 0", overflow); end
      keystrobe = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, cmd_valid); end
         n_cmp++; if (cmd_code !== exp_q[i]) begin n_err++; $display("FAIL b2b_code[%0d]: got %0d want %0d", i, cmd_code, exp_q[i]); end
         tick;
      end
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", cmd_valid); end
      cmd_ready = 1'b0;
   endtask

   task automatic test_invalid_and_reset;
      do_reset;
      keystrobe = 1'b1;
      keycode = 4'd14;
      tick; tick; tick;
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL inv_valid: got %b want 0", cmd_valid); end
      n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL inv_held: got %b want 0", held); end
      keycode = 4'd1;
      // E0..E0+6 push at E0, +4, +6 leaving three entries in REPEAT
      for (int i = 0; i < 7; i++) tick;
      n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL mid_held: got %b want 1", held); end
      n_cmp++; if (dut.wr_ptr - dut.rd_ptr !== 3'd3) begin n_err++; $display("FAIL mid_count: got %0d want 3", dut.wr_ptr - dut.rd_ptr); end
      reset = 1'b1;
      tick;
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %b want 0", cmd_valid); end
      n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL mrst_held: got %b want 0", held); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mrst_ovf: got %b want 0", overflow); end
      n_cmp++; if (cmd_code !== 4'd0) begin n_err++; $display("FAIL mrst_code: got %0d want 0", cmd_code); end
      reset = 1'b0;
      tick;
      n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL repress_valid: got %b want 1", cmd_valid); end
      n_cmp++; if (cmd_code !== 4'd1) begin n_err++; $display("FAIL repress_code: got %0d want 1", cmd_code); end
      n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL repress_held: got %b want 1", held); end
      keycode = 4'd13;
      tick;
      n_cmp++; if (held !== 1'b0) begin n_err++; $display("FAIL inv_release: got %b want 0", held); end
      keystrobe = 1'b0;
   endtask

   initial begin
      test_reset;
      test_single_tap;
      test_repeat_overflow;
      test_no_repeat_switch;
      test_back_to_back;
      test_invalid_and_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
